tube_field_gen: RTL and testbench

Parametrised obstacle generator for the flappy-bird playfield. It keeps NUM_TUBES tubes scrolling right-to-left and respawns each one off-screen with a pseudo-random gap. It also detects when a tube passes the bird column, keeps the score, and raises difficulty (faster scroll, narrower gap) every LEVEL_STEP passes. The renderer and collision logic consume its per-tube outputs.

---
 rtl/tube_field_gen.sv | 197 +++++++++++++++++++
 tb/tb_tube_field_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tube_field_gen.sv
// Scrolling obstacle field: loads, scrolls and respawns NUM_TUBES tubes, tracks score and level.
// Optional macro TUBE_FIELD_EXT_TICK_EN: moves are paced by frame_tick instead of the TICK_MAX counter.
module tube_field_gen #(
    parameter int          NUM_TUBES     = 3,
    parameter int          SCREEN_WIDTH  = 1024,
    parameter int          SCREEN_HEIGHT = 768,
    parameter int          TUBE_WIDTH    = 120,
    parameter int          TUBE_SPACING  = 400,
    parameter int          GAP_MAX       = 400,
    parameter int          GAP_MIN       = 200,
    parameter int          GAP_STEP      = 25,
    parameter int          GAP_MARGIN    = 50,
    parameter int          SPEED_MIN     = 2,
    parameter int          SPEED_MAX     = 6,
    parameter int          LEVEL_STEP    = 5,
    parameter int          BIRD_X        = 200,
    parameter int          TICK_MAX      = 1_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             game_rst,
    input  logic                             run,
    input  logic                             frame_tick,
    output logic [NUM_TUBES-1:0][10:0]       tube_x,
    output logic [NUM_TUBES-1:0][10:0]       gap_y,
    output logic [NUM_TUBES-1:0][9:0]        gap_h,
    output logic                             ready,
    output logic                             pass_pulse,
    output logic [15:0]                      score,
    output logic [3:0]                       level
);
    localparam int RAND_RANGE = SCREEN_HEIGHT - GAP_MAX - 2*GAP_MARGIN;
    localparam int IDX_W      = $clog2(NUM_TUBES);

    if (SCREEN_WIDTH + TUBE_WIDTH + (NUM_TUBES-1)*TUBE_SPACING > 2047) begin : g_width_chk
        $error("tube_field_gen: field does not fit the 11-bit tube_x");
    end
    if (TUBE_SPACING <= SPEED_MAX) begin : g_spacing_chk
        $error("tube_field_gen: TUBE_SPACING must exceed SPEED_MAX");
    end

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RUN} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           load_idx_q, load_idx_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [NUM_TUBES-1:0][10:0] tube_x_q, tube_x_d, gap_y_q, gap_y_d;
    logic [NUM_TUBES-1:0][9:0]  gap_h_q, gap_h_d;
    logic                       ready_q, ready_d, pass_q, pass_d;
    logic [15:0]                score_q, score_d;
    logic [3:0]                 level_q, level_d;
    logic [10:0]                cur_speed, new_gap_y;
    logic [9:0]                 cur_gap;
    logic                       tick, passed;
    int                         spd_i, gap_i, rnd_i;

    function automatic logic [10:0] x_init(input int i);
        return 11'(SCREEN_WIDTH + TUBE_WIDTH + i*TUBE_SPACING);
    endfunction

    // Difficulty derived from the registered level, so a level-up applies from the next move.
    always_comb begin
        spd_i = SPEED_MIN + int'(level_q);
        if (spd_i > SPEED_MAX) spd_i = SPEED_MAX;
        gap_i = GAP_MAX - int'(level_q) * GAP_STEP;
        if (gap_i < GAP_MIN) gap_i = GAP_MIN;
        rnd_i = int'(lfsr_q % 16'(RAND_RANGE));
        cur_speed = 11'(spd_i);
        cur_gap   = 10'(gap_i);
        new_gap_y = 11'(GAP_MARGIN + rnd_i + (GAP_MAX - gap_i) / 2);
    end

`ifdef TUBE_FIELD_EXT_TICK_EN
    assign tick = frame_tick;
`else
    localparam int CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_frame_tick;

    assign unused_frame_tick = frame_tick;
    assign tick = (cnt_q == CNT_W'(TICK_MAX - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_RUN && run && !game_rst && !tick) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        tube_x_d   = tube_x_q;
        gap_y_d    = gap_y_q;
        gap_h_d    = gap_h_q;
        ready_d    = ready_q;
        pass_d     = 1'b0;
        score_d    = score_q;
        level_d    = level_q;
        passed     = 1'b0;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (game_rst) begin
            state_d    = S_LOAD;
            load_idx_d = '0;
            ready_d    = 1'b0;
            score_d    = '0;
            level_d    = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    for (int i = 0; i < NUM_TUBES; i++) begin
                        if (i == int'(load_idx_q)) begin
                            tube_x_d[i] = x_init(i);
                            gap_y_d[i]  = new_gap_y;
                            gap_h_d[i]  = cur_gap;
                        end
                    end
                    if (load_idx_q == IDX_W'(NUM_TUBES - 1)) begin
                        load_idx_d = '0;
                        ready_d    = 1'b1;
                        state_d    = run ? S_RUN : S_IDLE;
                    end else begin
                        load_idx_d = load_idx_q + 1'b1;
                    end
                end
                S_IDLE: if (run) state_d = S_RUN;
                S_RUN: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end else if (tick) begin
                        for (int i = 0; i < NUM_TUBES; i++) begin
                            if (tube_x_q[i] <= cur_speed) begin
                                tube_x_d[i] = tube_x_q[i] + 11'(NUM_TUBES * TUBE_SPACING) - cur_speed;
                                gap_y_d[i]  = new_gap_y;
                                gap_h_d[i]  = cur_gap;
                            end else begin
                                tube_x_d[i] = tube_x_q[i] - cur_speed;
                                if (tube_x_q[i] > 11'(BIRD_X) && tube_x_d[i] <= 11'(BIRD_X))
                                    passed = 1'b1;
                            end
                        end
                        if (passed) begin
                            pass_d = 1'b1;
                            if (score_q != 16'hFFFF) begin
                                score_d = score_q + 16'd1;
                                if (score_d % 16'(LEVEL_STEP) == 16'd0 && level_q != 4'hF)
                                    level_d = level_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            load_idx_q <= '0;
            lfsr_q     <= LFSR_SEED;
            for (int i = 0; i < NUM_TUBES; i++) begin
                tube_x_q[i] <= x_init(i);
                gap_y_q[i]  <= 11'((SCREEN_HEIGHT - GAP_MAX) / 2);
                gap_h_q[i]  <= 10'(GAP_MAX);
            end
            ready_q <= 1'b0;
            pass_q  <= 1'b0;
            score_q <= '0;
            level_q <= '0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            lfsr_q     <= lfsr_d;
            tube_x_q   <= tube_x_d;
            gap_y_q    <= gap_y_d;
            gap_h_q    <= gap_h_d;
            ready_q    <= ready_d;
            pass_q     <= pass_d;
            score_q    <= score_d;
            level_q    <= level_d;
        end
    end

    assign tube_x     = tube_x_q;
    assign gap_y      = gap_y_q;
    assign gap_h      = gap_h_q;
    assign ready      = ready_q;
    assign pass_pulse = pass_q;
    assign score      = score_q;
    assign level      = level_q;
endmodule

// File: tb/tb_tube_field_gen.sv
// Randomized bench for tube_field_gen against a cycle-level behavioural model of the field.
module tb_tube_field_gen;
    localparam int N    = 3;
    localparam int TICK = 4;

    logic clk = 1'b0, rst = 1'b1, game_rst = 1'b0, run = 1'b0, frame_tick = 1'b0;
    logic [N-1:0][10:0] tube_x, gap_y;
    logic [N-1:0][9:0]  gap_h;
    logic        ready, pass_pulse;
    logic [15:0] score;
    logic [3:0]  level;

    tube_field_gen #(.NUM_TUBES(N), .TICK_MAX(TICK)) dut (
        .clk(clk), .rst(rst), .game_rst(game_rst), .run(run), .frame_tick(frame_tick),
        .tube_x(tube_x), .gap_y(gap_y), .gap_h(gap_h), .ready(ready),
        .pass_pulse(pass_pulse), .score(score), .level(level));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    int m_x[N], m_gy[N], m_gh[N];
    int m_score, m_level, m_mode, m_loaded, m_run_cyc; // mode: 0 load, 1 idle, 2 run
    bit m_ready, m_pass;
    logic [15:0] m_lfsr;

    function automatic int speed_of(input int lvl);
        return (2 + lvl > 6) ? 6 : 2 + lvl;
    endfunction
    function automatic int gap_of(input int lvl);
        return (400 - 25*lvl < 200) ? 200 : 400 - 25*lvl;
    endfunction
    function automatic int gy_of(input logic [15:0] l, input int lvl);
        return 50 + int'(l) % 268 + (400 - gap_of(lvl)) / 2;
    endfunction

    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 1144 + 400*i; m_gy[i] = 184; m_gh[i] = 400;
        end
        m_score = 0; m_level = 0; m_mode = 0; m_loaded = 0; m_run_cyc = 0;
        m_ready = 0; m_pass = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_move();
        int spd, old;
        bit hit;
        spd = speed_of(m_level);
        hit = 0;
        for (int i = 0; i < N; i++) begin
            old = m_x[i];
            if (old <= spd) begin
                m_x[i] = old + N*400 - spd; m_gy[i] = gy_of(m_lfsr, m_level); m_gh[i] = gap_of(m_level);
            end else begin
                m_x[i] = old - spd;
                if (old > 200 && m_x[i] <= 200) hit = 1;
            end
        end
        if (hit) begin
            m_pass = 1;
            if (m_score < 65535) begin
                m_score++;
                if (m_score % 5 == 0 && m_level < 15) m_level++;
            end
        end
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk);
            if (rst) model_init();
            else begin
                m_pass = 0;
                if (game_rst) begin
                    m_mode = 0; m_loaded = 0; m_score = 0; m_level = 0; m_ready = 0;
                end else if (m_mode == 0) begin
                    m_x[m_loaded]  = 1144 + 400*m_loaded;
                    m_gy[m_loaded] = gy_of(m_lfsr, m_level);
                    m_gh[m_loaded] = gap_of(m_level);
                    m_loaded++;
                    if (m_loaded == N) begin
                        m_loaded = 0; m_ready = 1; m_run_cyc = 0; m_mode = run ? 2 : 1;
                    end
                end else if (m_mode == 1) begin
                    if (run) begin m_mode = 2; m_run_cyc = 0; end
                end else if (!run) begin
                    m_mode = 1;
                end else begin
                    m_run_cyc++;
`ifdef TUBE_FIELD_EXT_TICK_EN
                    if (frame_tick) model_move();
`else
                    if (m_run_cyc % TICK == 0) model_move();
`endif
                end
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (!rst && cmp_en) begin
            for (int i = 0; i < N; i++) begin
                chk("tube_x", int'(tube_x[i]), m_x[i]);
                chk("gap_y", int'(gap_y[i]), m_gy[i]);
                chk("gap_h", int'(gap_h[i]), m_gh[i]);
            end
            chk("ready", int'(ready), int'(m_ready));
            chk("pass_pulse", int'(pass_pulse), int'(m_pass));
            chk("score", int'(score), m_score);
            chk("level", int'(level), m_level);
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, k, snap, found;
        int snapx[N];
        step(2);
        for (int i = 0; i < N; i++) begin
            chk("rst_tube_x", int'(tube_x[i]), 1144 + 400*i);
            chk("rst_gap_y", int'(gap_y[i]), 184);
            chk("rst_gap_h", int'(gap_h[i]), 400);
        end
        chk("rst_ready", int'(ready), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_pass", int'(pass_pulse), 0);

        rst = 1'b0; cmp_en = 1'b1;
        step(2);
        chk("ready_during_load", int'(ready), 0);
        step(1);
        chk("ready_after_load", int'(ready), 1);
        chk("load_x0", int'(tube_x[0]), 1144);
        chk("load_x1", int'(tube_x[1]), 1544);
        chk("load_x2", int'(tube_x[2]), 1944);
        for (int i = 0; i < N; i++) begin
            chk("load_gap_y_range", int'(gap_y[i] >= 50 && gap_y[i] <= 317), 1);
            chk("load_gap_h", int'(gap_h[i]), 400);
        end

        run = 1'b1;
`ifdef TUBE_FIELD_EXT_TICK_EN
        step(2);
        repeat (3) begin frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1); end
        chk("ext_3_ticks_x0", int'(tube_x[0]), 1138);
        run = 1'b0; frame_tick = 1'b1; step(4);
        chk("ext_frozen_x0", int'(tube_x[0]), 1138);
        run = 1'b1;
`else
        step(40);
        chk("nine_ticks_x0", int'(tube_x[0]), 1126);
        step(1);
        chk("ten_ticks_x0", int'(tube_x[0]), 1124);
        chk("no_pass_yet", int'(score), 0);
`endif

        n = 0;
        while (pass_pulse !== 1'b1 && n < 4000) begin step(1); n++; end
        chk("first_pass_seen", int'(pass_pulse), 1);
        chk("first_pass_x0", int'(tube_x[0]), 200);
        chk("first_pass_score", int'(score), 1);
        step(1);
        chk("pass_one_cycle", int'(pass_pulse), 0);

        n = 0;
        while (tube_x[0] != 11'd1200 && n < 3000) begin step(1); n++; end
        chk("respawn_x0", int'(tube_x[0]), 1200);
        chk("respawn_gap_h0", int'(gap_h[0]), 400);

        n = 0;
        while (score != 16'd5 && n < 8000) begin step(1); n++; end
        chk("score5", int'(score), 5);
        chk("level1", int'(level), 1);
        k = 0;
        for (int i = 1; i < N; i++) if (m_x[i] > m_x[k]) k = i;
        snap = m_x[k];
        n = 0;
        while (int'(tube_x[k]) == snap && n < 4*TICK) begin step(1); n++; end
        chk("level1_speed3", int'(tube_x[k]), snap - 3);

        found = 0; n = 0;
        while (found == 0 && n < 4000) begin
            for (int i = 0; i < N; i++) if (gap_h[i] == 10'd375) found = 1;
            if (found == 0) begin step(1); n++; end
        end
        chk("gap_375_after_levelup", found, 1);

        run = 1'b0;
        for (int i = 0; i < N; i++) snapx[i] = m_x[i];
        step(20);
        for (int i = 0; i < N; i++) chk("frozen_x", int'(tube_x[i]), snapx[i]);

        run = 1'b1;
        step(30);
        game_rst = 1'b1;
        step(1);
        game_rst = 1'b0;
        chk("grst_ready_low", int'(ready), 0);
        chk("grst_score", int'(score), 0);
        chk("grst_level", int'(level), 0);
        step(3);
        chk("grst_ready", int'(ready), 1);
        for (int i = 0; i < N; i++) chk("grst_tube_x", int'(tube_x[i]), 1144 + 400*i);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            game_rst   = ($urandom_range(0, 399) == 0);
            frame_tick = 1'($urandom_range(0, 1));
            step(1);
        end
        game_rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
